// File: rtl/mlp_layer_scheduler.sv
// Layer scheduler: time-multiplexes one neuron_dot_product across every neuron of a
// fully-connected layer, fetching each weight row and collecting results into layer_out.
module mlp_layer_scheduler #(
    parameter int INPUT_WIDTH    = 3,
    parameter int NUM_NEURONS    = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int RELU_EN        = 1,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic signed [DATA_WIDTH-1:0]           layer_in [INPUT_WIDTH],
    output logic                                   busy,
    output logic                                   done,
    output logic                                   layer_valid,
    output logic                                   err,
    output logic signed [DATA_WIDTH-1:0]           layer_out [NUM_NEURONS],
    output logic                                   w_rd_en,
    output logic [AW-1:0]                          w_addr,
    input  logic [(INPUT_WIDTH+1)*DATA_WIDTH-1:0]  w_rd_data,
    output logic signed [DATA_WIDTH-1:0]           nu_a [INPUT_WIDTH],
    output logic signed [DATA_WIDTH-1:0]           nu_w [INPUT_WIDTH],
    output logic signed [DATA_WIDTH-1:0]           nu_bias,
    output logic                                   nu_valid_in,
    input  logic                                   nu_valid_out,
    input  logic signed [DATA_WIDTH-1:0]           nu_a_out
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] ISSUE = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] STORE = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    logic [2:0]                   state;
    logic [AW-1:0]                idx;
    logic [TW-1:0]                cnt;
    logic signed [DATA_WIDTH-1:0] res_q;

    // Control strobes are pure decodes of the registered state.
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign layer_valid = (state == DONE) && !err;
    assign w_rd_en     = (state == FETCH);
    assign nu_valid_in = (state == ISSUE);
    assign w_addr      = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            res_q   <= '0;
            nu_bias <= '0;
            for (int unsigned i = 0; i < INPUT_WIDTH; i++) begin
                nu_a[i] <= '0;
                nu_w[i] <= '0;
            end
            for (int unsigned k = 0; k < NUM_NEURONS; k++) begin
                layer_out[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        nu_a  <= layer_in;
                        idx   <= '0;
                        err   <= 1'b0;
                        state <= FETCH;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    for (int unsigned i = 0; i < INPUT_WIDTH; i++) begin
                        nu_w[i] <= w_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                    nu_bias <= w_rd_data[INPUT_WIDTH*DATA_WIDTH +: DATA_WIDTH];
                    state   <= ISSUE;
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // Result is captured on the strobe so STORE never depends on the
                    // neuron holding its output afterwards.
                    if (nu_valid_out) begin
                        res_q <= nu_a_out;
                        state <= STORE;
                    end else if (cnt == TW'(TIMEOUT_CYCLES)) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                STORE: begin
                    layer_out[idx] <= ((RELU_EN != 0) && (res_q < 0)) ? '0 : res_q;
                    if (idx == AW'(NUM_NEURONS - 1)) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + AW'(1);
                        state <= FETCH;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_layer_scheduler.sv
// Scoreboard bench for mlp_layer_scheduler: a behavioural neuron stub and weight memory
// drive two DUTs (ReLU on/off); a monitor checks each layer completion against a model.
module tb_mlp_layer_scheduler;

    localparam int IW   = 3;
    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int T    = 64;
    localparam int P    = IW + 5;
    localparam int AW   = 2;
    localparam int ROWW = (IW + 1) * DW;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic signed [DW-1:0] layer_in [IW];

    logic busy0, done0, lv0, err0, wre0, nvi0;
    logic busy1, done1, lv1, err1, wre1, nvi1;
    logic [AW-1:0] wa0, wa1;
    logic signed [DW-1:0] lo0 [N];
    logic signed [DW-1:0] lo1 [N];
    logic signed [DW-1:0] na0 [IW];
    logic signed [DW-1:0] nw0 [IW];
    logic signed [DW-1:0] na1 [IW];
    logic signed [DW-1:0] nw1 [IW];
    logic signed [DW-1:0] nb0, nb1;

    logic [ROWW-1:0]      w_rd_data;
    logic                 nu_valid_out;
    logic signed [DW-1:0] nu_a_out;
    logic [ROWW-1:0]      rom [N];

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;
    int unsigned stall_idx = N;

    typedef struct packed {
        logic [31:0]          done_cyc;
        logic                 valid;
        logic                 err;
        logic [N-1:0][DW-1:0] out0;
        logic [N-1:0][DW-1:0] out1;
    } exp_t;

    exp_t sbq[$];
    logic [N-1:0][DW-1:0] model0;
    logic [N-1:0][DW-1:0] model1;
    logic signed [DW-1:0] next_in [IW];
    logic signed [DW-1:0] exp_in [IW];

    mlp_layer_scheduler #(
        .INPUT_WIDTH(IW), .NUM_NEURONS(N), .DATA_WIDTH(DW), .RELU_EN(1), .TIMEOUT_CYCLES(T)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .layer_in(layer_in),
        .busy(busy0), .done(done0), .layer_valid(lv0), .err(err0), .layer_out(lo0),
        .w_rd_en(wre0), .w_addr(wa0), .w_rd_data(w_rd_data),
        .nu_a(na0), .nu_w(nw0), .nu_bias(nb0), .nu_valid_in(nvi0),
        .nu_valid_out(nu_valid_out), .nu_a_out(nu_a_out)
    );

    mlp_layer_scheduler #(
        .INPUT_WIDTH(IW), .NUM_NEURONS(N), .DATA_WIDTH(DW), .RELU_EN(0), .TIMEOUT_CYCLES(T)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .layer_in(layer_in),
        .busy(busy1), .done(done1), .layer_valid(lv1), .err(err1), .layer_out(lo1),
        .w_rd_en(wre1), .w_addr(wa1), .w_rd_data(w_rd_data),
        .nu_a(na1), .nu_w(nw1), .nu_bias(nb1), .nu_valid_in(nvi1),
        .nu_valid_out(nu_valid_out), .nu_a_out(nu_a_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous weight memory; garbage on idle cycles exposes mistimed loads.
    always @(posedge clk) w_rd_data <= wre0 ? rom[wa0] : ROWW'({$urandom, $urandom});

    function automatic logic [DW-1:0] stub_result();
        longint acc;
        acc = longint'(nb0);
        for (int unsigned i = 0; i < IW; i++) acc += longint'(na0[i]) * longint'(nw0[i]);
        return acc[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] ref_neuron(input int unsigned k);
        longint acc;
        acc = longint'($signed(rom[k][IW*DW +: DW]));
        for (int unsigned i = 0; i < IW; i++)
            acc += longint'(exp_in[i]) * longint'($signed(rom[k][i*DW +: DW]));
        return acc[DW-1:0];
    endfunction

    // Neuron stub: result IW+1 cycles after issue, or never for stalled neurons;
    // stray strobes are sprinkled in outside WAIT.
    logic        in_wait, stall_now;
    int unsigned left;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nu_valid_out <= 1'b0;
            nu_a_out     <= '0;
            in_wait      <= 1'b0;
            stall_now    <= 1'b0;
            left         <= 0;
        end else begin
            nu_valid_out <= 1'b0;
            if (nvi0) begin
                in_wait   <= 1'b1;
                left      <= IW;
                stall_now <= (int'(wa0) >= int'(stall_idx));
            end else if (in_wait && done0) begin
                in_wait <= 1'b0;
            end else if (in_wait && !stall_now) begin
                if (left == 1) begin
                    nu_valid_out <= 1'b1;
                    nu_a_out     <= stub_result();
                    in_wait      <= 1'b0;
                end else begin
                    left <= left - 1;
                end
            end else if (!in_wait && $urandom_range(0, 7) == 0) begin
                nu_valid_out <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic abort_run(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
        finish_run();
    endtask

    task automatic check_reset();
        logic bad0, bad1;
        bad0 = busy0 | done0 | lv0 | err0 | wre0 | nvi0 | (|wa0) | (|nb0);
        bad1 = busy1 | done1 | lv1 | err1 | wre1 | nvi1 | (|wa1) | (|nb1);
        for (int unsigned i = 0; i < IW; i++) begin
            bad0 |= (|na0[i]) | (|nw0[i]);
            bad1 |= (|na1[i]) | (|nw1[i]);
        end
        for (int unsigned k = 0; k < N; k++) begin
            bad0 |= |lo0[k];
            bad1 |= |lo1[k];
        end
        check("reset_outputs_relu", bad0, 1'b0);
        check("reset_outputs_norelu", bad1, 1'b0);
    endtask

    // Monitor: pops an expectation on every done and checks operand stability.
    initial begin
        exp_t e;
        logic [N-1:0][DW-1:0] f0, f1;
        logic signed [DW-1:0] snap_a [IW];
        logic signed [DW-1:0] snap_w [IW];
        logic signed [DW-1:0] snap_b;
        bit watching = 0, stable = 0, saw_vo = 0, done_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                watching  = 0;
                done_prev = 0;
                continue;
            end
            if (done_prev) check("busy_after_done", busy0, 1'b0);
            done_prev = done0;
            if (nvi0) begin
                snap_a = na0; snap_w = nw0; snap_b = nb0;
                watching = 1; stable = 1; saw_vo = 0;
            end else if (watching) begin
                for (int unsigned i = 0; i < IW; i++)
                    if (na0[i] !== snap_a[i] || nw0[i] !== snap_w[i]) stable = 0;
                if (nb0 !== snap_b) stable = 0;
                if (saw_vo) begin
                    check("operands_stable", stable, 1'b1);
                    watching = 0;
                end else if (nu_valid_out) begin
                    saw_vo = 1;
                end
            end
            if (done0) begin
                watching = 0;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                end else begin
                    e = sbq.pop_front();
                    for (int unsigned k = 0; k < N; k++) begin
                        f0[k] = lo0[k];
                        f1[k] = lo1[k];
                    end
                    check("done_cycle", cyc, e.done_cyc);
                    check("layer_valid_relu", lv0, e.valid);
                    check("err_relu", err0, e.err);
                    check("layer_valid_norelu", lv1, e.valid);
                    check("err_norelu", err1, e.err);
                    check("done_norelu", done1, 1'b1);
                    check("layer_out_relu", f0, e.out0);
                    check("layer_out_norelu", f1, e.out1);
                end
            end
        end
    end

    task automatic wait_idle();
        int unsigned guard = 0;
        while (busy0) begin
            if (guard++ > 1000) abort_run("wait_idle");
            @(negedge clk);
        end
    endtask

    task automatic launch(input bit b2b, input bit disturb);
        exp_t e;
        int unsigned c, guard;
        logic [DW-1:0] r;
        wait_idle();
        if (!b2b) repeat ($urandom_range(0, 3)) @(negedge clk);
        layer_in = next_in;
        exp_in   = next_in;
        c = cyc;
        start = 1'b1;
        for (int unsigned k = 0; k < N; k++) begin
            if (k < stall_idx) begin
                r = ref_neuron(k);
                model1[k] = r;
                model0[k] = ($signed(r) < 0) ? '0 : r;
            end
        end
        e.valid    = (stall_idx >= N);
        e.err      = !e.valid;
        e.done_cyc = e.valid ? c + N*P + 1 : c + stall_idx*P + 3 + T + 2;
        e.out0     = model0;
        e.out1     = model1;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("err_cleared_on_start", err0, 1'b0);
        check("busy_after_start", busy0, 1'b1);
        guard = 0;
        while (busy0) begin
            if (guard++ > 1000) abort_run("layer_done");
            if (disturb) begin
                if ($urandom_range(0, 7) == 0) start = 1'b1;
                if ($urandom_range(0, 5) == 0)
                    for (int unsigned i = 0; i < IW; i++) layer_in[i] = DW'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic randomize_layer();
        for (int unsigned k = 0; k < N; k++) rom[k] = ROWW'({$urandom, $urandom});
        for (int unsigned i = 0; i < IW; i++) next_in[i] = DW'($urandom);
    endtask

    task automatic mid_layer_reset();
        int unsigned c;
        wait_idle();
        randomize_layer();
        stall_idx = N;
        layer_in = next_in;
        c = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + 2*P + 5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset();
        model0 = '0;
        model1 = '0;
        sbq.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        abort_run("global_timeout");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        model0 = '0;
        model1 = '0;
        for (int unsigned i = 0; i < IW; i++) begin
            layer_in[i] = '0;
            next_in[i]  = '0;
        end
        randomize_layer();
        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        @(negedge clk);

        // Basic layer: inputs {1,2,3}, neuron k weights {k+1,1,-1}, bias k.
        next_in[0] = 16'sd1; next_in[1] = 16'sd2; next_in[2] = 16'sd3;
        for (int unsigned k = 0; k < N; k++) begin
            rom[k][0*DW +: DW] = DW'(k + 1);
            rom[k][1*DW +: DW] = 16'sd1;
            rom[k][2*DW +: DW] = -16'sd1;
            rom[k][3*DW +: DW] = DW'(k);
        end
        launch(1'b0, 1'b0);

        // ReLU: row 0 weights {-5,0,0}, bias 0, back-to-back with the previous layer.
        rom[0] = '0;
        rom[0][0*DW +: DW] = -16'sd5;
        launch(1'b1, 1'b0);

        randomize_layer();
        launch(1'b0, 1'b1);

        // Timeout on the first neuron, then a layer that must clear err.
        randomize_layer();
        stall_idx = 0;
        launch(1'b0, 1'b1);
        stall_idx = N;
        randomize_layer();
        launch(1'b1, 1'b0);

        randomize_layer();
        stall_idx = 2;
        launch(1'b0, 1'b0);
        stall_idx = N;

        mid_layer_reset();
        randomize_layer();
        launch(1'b0, 1'b1);

        for (int unsigned n = 0; n < 20; n++) begin
            randomize_layer();
            stall_idx = ($urandom_range(0, 4) == 0) ? $urandom_range(0, N - 1) : N;
            launch(1'($urandom_range(0, 1)), 1'b1);
        end
        stall_idx = N;

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        finish_run();
    end

endmodule
